life_grid_core: RTL

Parametrised Conway-style cellular-automaton grid core, the next generation of the team's fixed LED grid design: configurable COLS×ROWS array, host-loadable rows, single-step and free-running evolution, row-scanned display output. Sits directly behind the Tiny Tapeout pin wrapper and uses the standard TT user-project port set.

---
 rtl/life_grid_pkg.sv | 25 ++
 rtl/life_row_next.sv | 57 +++++
 rtl/life_grid_core.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/life_grid_pkg.sv
// Shared encodings and the B3/S23 cell rule for the life grid core.
package life_grid_pkg;

  typedef enum logic [1:0] {
    CMD_CLEAR = 2'b00,
    CMD_WRITE = 2'b01,
    CMD_STEP  = 2'b10,
    CMD_RUN   = 2'b11
  } cmd_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_STEP = 1'b1
  } state_e;

  localparam logic [3:0] BIRTH_COUNT = 4'd3;
  localparam logic [3:0] SURVIVE_LO  = 4'd2;
  localparam logic [3:0] SURVIVE_HI  = 4'd3;

  function automatic logic cell_next(input logic alive, input logic [3:0] count);
    return (count == BIRTH_COUNT) ||
           (alive && (count >= SURVIVE_LO) && (count <= SURVIVE_HI));
  endfunction

endpackage

// File: rtl/life_row_next.sv
// Combinational next-generation row from the above/current/below rows.
// LIFE_GRID_WRAP_EN: column 0 and column COLS-1 are neighbours; otherwise off-grid cells are dead.
module life_row_next
  import life_grid_pkg::*;
#(
  parameter int COLS = 8
) (
  input  logic [COLS-1:0] above_i,
  input  logic [COLS-1:0] cur_i,
  input  logic [COLS-1:0] below_i,
  output logic [COLS-1:0] next_o
);

  // Bit c of a west vector holds the cell at column c-1; east holds column c+1.
  function automatic logic [COLS-1:0] west(input logic [COLS-1:0] r);
`ifdef LIFE_GRID_WRAP_EN
    return {r[COLS-2:0], r[COLS-1]};
`else
    return {r[COLS-2:0], 1'b0};
`endif
  endfunction

  function automatic logic [COLS-1:0] east(input logic [COLS-1:0] r);
`ifdef LIFE_GRID_WRAP_EN
    return {r[0], r[COLS-1:1]};
`else
    return {1'b0, r[COLS-1:1]};
`endif
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] n);
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) s = s + {3'b000, n[i]};
    return s;
  endfunction

  logic [COLS-1:0] above_w, above_e, cur_w, cur_e, below_w, below_e;

  assign above_w = west(above_i);
  assign above_e = east(above_i);
  assign cur_w   = west(cur_i);
  assign cur_e   = east(cur_i);
  assign below_w = west(below_i);
  assign below_e = east(below_i);

  always_comb begin
    next_o = '0;
    for (int c = 0; c < COLS; c++) begin
      next_o[c] = cell_next(cur_i[c],
                            popcount8({above_w[c], above_i[c], above_e[c],
                                       cur_w[c], cur_e[c],
                                       below_w[c], below_i[c], below_e[c]}));
    end
  end

endmodule

// File: rtl/life_grid_core.sv
// COLSxROWS B3/S23 automaton with host row loading, step/free-run evolution and row-scanned display.
// Build macro LIFE_GRID_WRAP_EN selects toroidal edges; undefined means dead cells beyond the border.
module life_grid_core
  import life_grid_pkg::*;
#(
  parameter int COLS          = 8,
  parameter int ROWS          = 8,
  parameter int SCAN_DIV_LOG2 = 4,
  parameter int RUN_PERIOD    = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int RCW = (RUN_PERIOD > 1) ? $clog2(RUN_PERIOD) : 1;
  localparam int DW  = (SCAN_DIV_LOG2 > 0) ? SCAN_DIV_LOG2 : 1;

  localparam logic [RW-1:0]  ROW_LAST = RW'(ROWS - 1);
  localparam logic [RCW-1:0] RUN_TERM = RCW'(RUN_PERIOD - 1);
  localparam logic [DW-1:0]  DIV_TERM = DW'((1 << SCAN_DIV_LOG2) - 1);

  logic strb_s1_q, strb_s2_q, strb_s3_q;
  logic accept;
  cmd_e cmd;

  state_e          state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic [RW-1:0]   wptr_q, wptr_d;
  logic [COLS-1:0] grid_q [ROWS];
  logic [COLS-1:0] grid_d [ROWS];
  logic [COLS-1:0] prev_q, prev_d;
`ifdef LIFE_GRID_WRAP_EN
  logic [COLS-1:0] row0_q, row0_d;
`endif
  logic            run_q, run_d;
  logic [RCW-1:0]  run_cnt_q, run_cnt_d;
  logic            run_tick, step_go;

  logic [DW-1:0]   div_q, div_d;
  logic [RW-1:0]   scan_row_q, scan_row_d;
  logic            scan_adv;
  logic [7:0]      uo_q, uo_d;
  logic            frame_q, frame_d;
  logic            empty_q, empty_d;

  logic [COLS-1:0] above, below, row_next;
  logic            busy;
  logic            unused;

  assign unused = &{1'b0, ena, uio_in[7:3], ui_in};

  // Strobe synchroniser; command and data pins are held stable by the host while it is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strb_s1_q <= 1'b0;
      strb_s2_q <= 1'b0;
      strb_s3_q <= 1'b0;
    end else begin
      strb_s1_q <= uio_in[0];
      strb_s2_q <= strb_s1_q;
      strb_s3_q <= strb_s2_q;
    end
  end

  assign accept   = strb_s2_q & ~strb_s3_q;
  assign cmd      = cmd_e'(uio_in[2:1]);
  assign busy     = (state_q == S_STEP);
  assign run_tick = run_q && (run_cnt_q == RUN_TERM);

  // Row r is rewritten in place, so its original value is kept in prev_q for row r+1.
  always_comb begin
`ifdef LIFE_GRID_WRAP_EN
    above = (row_q == '0) ? grid_q[ROWS-1] : prev_q;
    below = (row_q == ROW_LAST) ? row0_q : grid_q[row_q + RW'(1)];
`else
    above = (row_q == '0) ? '0 : prev_q;
    below = (row_q == ROW_LAST) ? '0 : grid_q[row_q + RW'(1)];
`endif
  end

  life_row_next #(.COLS(COLS)) u_row_next (
    .above_i (above),
    .cur_i   (grid_q[row_q]),
    .below_i (below),
    .next_o  (row_next)
  );

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    wptr_d  = wptr_q;
    grid_d  = grid_q;
    prev_d  = prev_q;
    run_d   = run_q;
    step_go = 1'b0;
`ifdef LIFE_GRID_WRAP_EN
    row0_d  = row0_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (cmd)
            CMD_CLEAR: begin
              for (int r = 0; r < ROWS; r++) grid_d[r] = '0;
              wptr_d = '0;
            end
            CMD_WRITE: begin
              grid_d[wptr_q] = ui_in[COLS-1:0];
              wptr_d = (wptr_q == ROW_LAST) ? '0 : wptr_q + RW'(1);
            end
            CMD_STEP: step_go = 1'b1;
            CMD_RUN:  run_d   = ~run_q;
            default:  ;
          endcase
        end
        // A run tick and a host STEP in the same cycle merge into one generation.
        if (run_tick) step_go = 1'b1;
        if (step_go) begin
          state_d = S_STEP;
          row_d   = '0;
        end
      end
      S_STEP: begin
        grid_d[row_q] = row_next;
        prev_d        = grid_q[row_q];
`ifdef LIFE_GRID_WRAP_EN
        if (row_q == '0) row0_d = grid_q[0];
`endif
        if (row_q == ROW_LAST) state_d = S_IDLE;
        else                   row_d   = row_q + RW'(1);
      end
      default: state_d = S_IDLE;
    endcase

    if (!(run_q && run_d))      run_cnt_d = '0;
    else if (run_cnt_q == RUN_TERM) run_cnt_d = '0;
    else                        run_cnt_d = run_cnt_q + RCW'(1);
  end

  always_comb begin
    scan_adv   = (div_q == DIV_TERM);
    div_d      = scan_adv ? '0 : div_q + DW'(1);
    scan_row_d = scan_row_q;
    if (scan_adv) scan_row_d = (scan_row_q == ROW_LAST) ? '0 : scan_row_q + RW'(1);
    uo_d       = 8'(grid_q[scan_row_q]);
    // frame marks the cycle in which uo_out carries row 0.
    frame_d    = (scan_row_q == '0);
    empty_d    = 1'b1;
    for (int r = 0; r < ROWS; r++) empty_d = empty_d & ~(|grid_q[r]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      wptr_q     <= '0;
      grid_q     <= '{default: '0};
      prev_q     <= '0;
`ifdef LIFE_GRID_WRAP_EN
      row0_q     <= '0;
`endif
      run_q      <= 1'b0;
      run_cnt_q  <= '0;
      div_q      <= '0;
      scan_row_q <= '0;
      uo_q       <= 8'h00;
      frame_q    <= 1'b1;
      empty_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      wptr_q     <= wptr_d;
      grid_q     <= grid_d;
      prev_q     <= prev_d;
`ifdef LIFE_GRID_WRAP_EN
      row0_q     <= row0_d;
`endif
      run_q      <= run_d;
      run_cnt_q  <= run_cnt_d;
      div_q      <= div_d;
      scan_row_q <= scan_row_d;
      uo_q       <= uo_d;
      frame_q    <= frame_d;
      empty_q    <= empty_d;
    end
  end

  assign uo_out  = uo_q;
  assign uio_out = {busy, run_q, frame_q, empty_q, 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule
